// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg
// Definitions shared by the stopwatch front end and the counter stage:
// FSM state encodings, time field widths and a packed time record.
// No ports.
package stopwatch_ctrl_pkg;

   localparam int HOURS_W   = 4;
   localparam int MINUTES_W = 6;
   localparam int SECONDS_W = 6;
   localparam int MS_W      = 10;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_PAUSED  = 2'd2;
   localparam logic [1:0] ST_LAP     = 2'd3;

   typedef struct packed {
      logic [HOURS_W-1:0]   hours;
      logic [MINUTES_W-1:0] minutes;
      logic [SECONDS_W-1:0] seconds;
      logic [MS_W-1:0]      milliseconds;
   } time_t;

   // The counter runs in RUNNING and in LAP. In LAP only the display is frozen.
   function automatic logic is_counting(input logic [1:0] st);
      return (st == ST_RUNNING) || (st == ST_LAP);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// button_debounce
// This module conditions one raw push-button. The raw input passes through a
// two-flop synchronizer. A change is accepted only after the synchronized
// value has differed from the accepted level for DEBOUNCE_CYCLES
// consecutive cycles.
// Ports:
//   clk        in   system tick clock
//   reset      in   synchronous, active-high
//   btn_raw    in   asynchronous raw button, 1 = pressed
//   btn_level  out  debounced level
//   btn_press  out  one-cycle pulse on a debounced 0->1 edge
module button_debounce
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         btn_level <= 1'b0;
         level_q   <= 1'b0;
         cnt       <= '0;
      end else begin
         sync_1  <= btn_raw;
         sync_2  <= sync_1;
         level_q <= btn_level;
         // The counter holds the number of consecutive disagreeing samples.
         // It clears when the limit is reached, so it never wraps.
         if (sync_2 == btn_level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            btn_level <= sync_2;
            cnt       <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign btn_press = btn_level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// This is the front end for the stopwatch counter. It debounces the two
// buttons and runs the start/pause/lap/reset sequencing. It also produces
// the display values, which are either live or frozen on a lap.
// Build option: define STOPWATCH_LAP_EN to include the LAP state and the
// frozen display. Without it, a reset/lap press while running is ignored
// and lap_active is tied low.
// Ports:
//   clk, reset                 tick clock, synchronous active-high reset
//   btn_start_stop             raw start/stop button
//   btn_reset_lap              raw reset/lap button
//   hours_in .. milliseconds_in  time fields from the counter
//   start_signal               counter enable
//   counter_reset              counter clear; held during reset, then a
//                              one-cycle pulse when PAUSED goes to IDLE
//   *_disp                     registered display values
//   lap_active                 display frozen
//   state                      current FSM state
//
// state      | meaning
// IDLE    0  | counter cleared and stopped
// RUNNING 1  | counting, display live
// PAUSED  2  | stopped, display live
// LAP     3  | counting, display frozen at the lap capture
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_start_stop,
   input  logic                 btn_reset_lap,
   input  logic [HOURS_W-1:0]   hours_in,
   input  logic [MINUTES_W-1:0] minutes_in,
   input  logic [SECONDS_W-1:0] seconds_in,
   input  logic [MS_W-1:0]      milliseconds_in,
   output logic                 start_signal,
   output logic                 counter_reset,
   output logic [HOURS_W-1:0]   hours_disp,
   output logic [MINUTES_W-1:0] minutes_disp,
   output logic [SECONDS_W-1:0] seconds_disp,
   output logic [MS_W-1:0]      milliseconds_disp,
   output logic                 lap_active,
   output logic [1:0]           state
);

   logic       ss_level;
   logic       ss_press;
   logic       rl_level;
   logic       rl_press;
   logic [1:0] state_nx;
   logic       clear_nx;
   logic       hold_disp;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start_stop (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_start_stop),
      .btn_level (ss_level),
      .btn_press (ss_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset_lap (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_reset_lap),
      .btn_level (rl_level),
      .btn_press (rl_press)
   );

   // Start/stop has priority. When both buttons are pressed in the same
   // cycle, the reset/lap press is dropped.
   always_comb begin
      state_nx = state;
      clear_nx = 1'b0;
      if (ss_press) begin
         case (state)
            ST_IDLE:    state_nx = ST_RUNNING;
            ST_RUNNING: state_nx = ST_PAUSED;
            ST_PAUSED:  state_nx = ST_RUNNING;
            ST_LAP:     state_nx = ST_PAUSED;
            default:    state_nx = ST_IDLE;
         endcase
      end else if (rl_press) begin
         case (state)
            ST_RUNNING: begin
`ifdef STOPWATCH_LAP_EN
               state_nx = ST_LAP;
`else
               state_nx = ST_RUNNING;
`endif
            end
            ST_LAP:     state_nx = ST_RUNNING;
            ST_PAUSED: begin
               state_nx = ST_IDLE;
               clear_nx = 1'b1;
            end
            default:    state_nx = state;
         endcase
      end
   end

`ifdef STOPWATCH_LAP_EN
   // The display registers also act as the lap capture. They load *_in on
   // the edge that enters LAP, and then hold while the FSM stays in LAP.
   assign hold_disp = (state == ST_LAP) && (state_nx == ST_LAP);

   always_ff @(posedge clk) begin
      if (reset) lap_active <= 1'b0;
      else       lap_active <= (state_nx == ST_LAP);
   end
`else
   assign hold_disp  = 1'b0;
   assign lap_active = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_IDLE;
         start_signal      <= 1'b0;
         counter_reset     <= 1'b1;
         hours_disp        <= '0;
         minutes_disp      <= '0;
         seconds_disp      <= '0;
         milliseconds_disp <= '0;
      end else begin
         state         <= state_nx;
         start_signal  <= is_counting(state_nx);
         counter_reset <= clear_nx;
         if (!hold_disp) begin
            hours_disp        <= hours_in;
            minutes_disp      <= minutes_in;
            seconds_disp      <= seconds_in;
            milliseconds_disp <= milliseconds_in;
         end
      end
   end

endmodule
